// File: rtl/rob_dispatch_if.sv
// Purpose: bundle of every rob_dispatch signal except clock and reset.
//   It carries the decode-side push handshake, the flush/enable controls,
//   the ROB/RS/SLB status inputs and the ROB insert / issue outputs.
// Modports:
//   master - the environment (decode, ROB, RS, SLB); drives the controls,
//            the decoded fields and the status, and observes the outputs.
//   slave  - the rob_dispatch block itself.
interface rob_dispatch_if;
    logic        rdy;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic [5:0]  in_order;
    logic [31:0] in_dest;
    logic [31:0] in_topc;
    logic        in_jump;
    logic        in_done;
    logic        in_mem;
    logic [31:0] rob_size;
    logic [31:0] rob_r;
    logic        rs_full;
    logic        slb_full;
    logic        Insq_ROB;
    logic        ROB_add;
    logic [31:0] data1;
    logic [31:0] rob_r_;
    logic [31:0] rob_pc_;
    logic [31:0] rob_inst_;
    logic [5:0]  rob_order_;
    logic [31:0] rob_dest_;
    logic [31:0] rob_topc_;
    logic        rob_ready_;
    logic        rob_jump_;
    logic        to_rs;
    logic        to_slb;
    logic [31:0] issue_tag;

    modport master (
        output rdy, clear, in_valid, in_pc, in_inst, in_order, in_dest, in_topc,
               in_jump, in_done, in_mem, rob_size, rob_r, rs_full, slb_full,
        input  in_ready, Insq_ROB, ROB_add, data1, rob_r_, rob_pc_, rob_inst_,
               rob_order_, rob_dest_, rob_topc_, rob_ready_, rob_jump_, to_rs,
               to_slb, issue_tag
    );

    modport slave (
        input  rdy, clear, in_valid, in_pc, in_inst, in_order, in_dest, in_topc,
               in_jump, in_done, in_mem, rob_size, rob_r, rs_full, slb_full,
        output in_ready, Insq_ROB, ROB_add, data1, rob_r_, rob_pc_, rob_inst_,
               rob_order_, rob_dest_, rob_topc_, rob_ready_, rob_jump_, to_rs,
               to_slb, issue_tag
    );
endinterface

// File: rtl/rob_dispatch.sv
// Purpose: in-order instruction queue and ROB allocator. Buffers decoded
//   instructions and, at most once per cycle, writes the oldest one into the
//   ROB entry after the current tail while steering it to the RS (ALU/branch)
//   or the SLB (load/store), tagged with that ROB index.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - rob_dispatch_if.slave: push handshake, rdy/clear, ROB occupancy
//          and tail, RS/SLB full flags, ROB insert fields and issue outputs
module rob_dispatch #(
    parameter int QDEPTH    = 16,
    parameter int ROB_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    rob_dispatch_if.slave bus
);
    localparam int AW = $clog2(QDEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [5:0]  order;
        logic [31:0] dest;
        logic [31:0] topc;
        logic        jump;
        logic        done;
        logic        mem;
    } entry_t;

    entry_t        q [QDEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;

    entry_t        hd;
    entry_t        in_e;
    logic          full;
    logic          push;
    logic          fire;
    logic          head_ok;
    logic [31:0]   next_tag;

    always_comb begin
        in_e = '{pc: bus.in_pc, inst: bus.in_inst, order: bus.in_order,
                 dest: bus.in_dest, topc: bus.in_topc, jump: bus.in_jump,
                 done: bus.in_done, mem: bus.in_mem};
        hd   = q[head];
        full = (count == (AW+1)'(QDEPTH));
        bus.in_ready = !full;
        push = bus.in_valid && !full && bus.rdy && !bus.clear && !rst;
        // Only the head's own destination unit matters; a blocked head
        // stalls everything behind it.
        head_ok = hd.mem ? !bus.slb_full : !bus.rs_full;
        fire = !rst && bus.rdy && !bus.clear && (count != '0) &&
               (bus.rob_size < 32'(ROB_DEPTH)) && head_ok;
        next_tag = (bus.rob_r + 32'd1) & 32'(ROB_DEPTH - 1);

        bus.Insq_ROB   = 1'b0;
        bus.ROB_add    = 1'b0;
        bus.data1      = '0;
        bus.rob_r_     = '0;
        bus.issue_tag  = '0;
        bus.rob_pc_    = '0;
        bus.rob_inst_  = '0;
        bus.rob_order_ = '0;
        bus.rob_dest_  = '0;
        bus.rob_topc_  = '0;
        bus.rob_ready_ = 1'b0;
        bus.rob_jump_  = 1'b0;
        bus.to_rs      = 1'b0;
        bus.to_slb     = 1'b0;
        if (fire) begin
            bus.Insq_ROB   = 1'b1;
            bus.ROB_add    = 1'b1;
            bus.data1      = next_tag;
            bus.rob_r_     = next_tag;
            bus.issue_tag  = next_tag;
            bus.rob_pc_    = hd.pc;
            bus.rob_inst_  = hd.inst;
            bus.rob_order_ = hd.order;
            bus.rob_dest_  = hd.dest;
            bus.rob_topc_  = hd.topc;
            bus.rob_ready_ = hd.done;
            bus.rob_jump_  = hd.jump;
            bus.to_rs      = !hd.mem;
            bus.to_slb     = hd.mem;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.rdy) begin
            if (push) tail <= tail + 1'b1;
            if (fire) head <= head + 1'b1;
            unique case ({push, fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: only entries between head and tail are read.
    always_ff @(posedge clk) begin
        if (push) q[tail] <= in_e;
    end
endmodule

// File: tb/tb_rob_dispatch.sv
module tb_rob_dispatch;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rob_dispatch_if bus();

    rob_dispatch #(.QDEPTH(16), .ROB_DEPTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [5:0]  order;
        logic [31:0] dest;
        logic [31:0] topc;
        logic        jump;
        logic        done;
        logic        mem;
    } ent_t;

    ent_t mq[$];
    int   pass_cnt = 0;
    int   total    = 0;
    bit   check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit model_fire();
        if (rst || !bus.rdy || bus.clear || mq.size() == 0) return 1'b0;
        if (bus.rob_size >= 32'd16) return 1'b0;
        return mq[0].mem ? !bus.slb_full : !bus.rs_full;
    endfunction

    // Reference queue: flush on rst/clear, else pop the head on fire and
    // append the offered instruction when there was room before the edge.
    always @(posedge clk) begin
        bit   f;
        bit   p;
        ent_t e;
        if (rst || bus.clear) begin
            mq.delete();
        end else if (bus.rdy) begin
            f = model_fire();
            p = bus.in_valid && (mq.size() < 16);
            e = '{bus.in_pc, bus.in_inst, bus.in_order, bus.in_dest,
                  bus.in_topc, bus.in_jump, bus.in_done, bus.in_mem};
            if (f) void'(mq.pop_front());
            if (p) mq.push_back(e);
        end
    end

    always @(negedge clk) begin
        bit          f;
        logic [31:0] tag;
        ent_t        h;
        if (check_en) begin
            f   = model_fire();
            tag = f ? ((bus.rob_r + 32'd1) % 32'd16) : 32'd0;
            h   = '{32'd0, 32'd0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
            if (f) h = mq[0];
            chk("Insq_ROB",   bus.Insq_ROB,   f);
            chk("ROB_add",    bus.ROB_add,    f);
            chk("data1",      bus.data1,      tag);
            chk("rob_r_",     bus.rob_r_,     tag);
            chk("issue_tag",  bus.issue_tag,  tag);
            chk("rob_pc_",    bus.rob_pc_,    h.pc);
            chk("rob_inst_",  bus.rob_inst_,  h.inst);
            chk("rob_order_", bus.rob_order_, h.order);
            chk("rob_dest_",  bus.rob_dest_,  h.dest);
            chk("rob_topc_",  bus.rob_topc_,  h.topc);
            chk("rob_ready_", bus.rob_ready_, h.done);
            chk("rob_jump_",  bus.rob_jump_,  h.jump);
            chk("to_rs",      bus.to_rs,      f && !h.mem);
            chk("to_slb",     bus.to_slb,     f && h.mem);
            chk("in_ready",   bus.in_ready,   mq.size() < 16);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic mem,
                         input logic done, input logic jump);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_inst  = pc ^ 32'h0000_0093;
        bus.in_order = pc[7:2] ^ {5'd0, mem};
        bus.in_dest  = {27'd0, pc[6:2]};
        bus.in_topc  = pc + 32'd4;
        bus.in_mem   = mem;
        bus.in_done  = done;
        bus.in_jump  = jump;
    endtask

    task automatic push1(input logic [31:0] pc, input logic mem,
                         input logic done, input logic jump);
        offer(pc, mem, done, jump);
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.rdy = 1'b1;  bus.clear = 1'b0;  bus.in_valid = 1'b0;
        bus.in_pc = '0;  bus.in_inst = '0;  bus.in_order = '0;  bus.in_dest = '0;
        bus.in_topc = '0; bus.in_jump = 1'b0; bus.in_done = 1'b0; bus.in_mem = 1'b0;
        bus.rob_size = '0; bus.rob_r = '0; bus.rs_full = 1'b0; bus.slb_full = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("reset_insq", bus.Insq_ROB, 1'b0);
        chk("reset_data1", bus.data1, 32'd0);
        rst = 1'b0;
        check_en = 1'b1;
        tick();

        // 1: single ADDI dispatches the cycle after its push
        push1(32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_insq", bus.Insq_ROB, 1'b1);
        chk("t1_data1", bus.data1, 32'd1);
        chk("t1_pc", bus.rob_pc_, 32'h0);
        chk("t1_to_rs", bus.to_rs, 1'b1);
        tick();
        @(negedge clk);
        chk("t1_empty", bus.Insq_ROB, 1'b0);
        tick();

        // 2: ROB full holds the head
        bus.rob_size = 32'd16;
        push1(32'h100, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_stall", bus.Insq_ROB, 1'b0);
            tick();
        end
        bus.rob_size = 32'd15;
        @(negedge clk);
        chk("t2_fire", bus.Insq_ROB, 1'b1);
        chk("t2_pc", bus.rob_pc_, 32'h100);
        tick();
        bus.rob_size = 32'd0;

        // 3: tag wraps from 15 to 0
        bus.rob_r = 32'd15;
        push1(32'h200, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("t3_data1", bus.data1, 32'd0);
        chk("t3_rob_r_", bus.rob_r_, 32'd0);
        chk("t3_tag", bus.issue_tag, 32'd0);
        chk("t3_insq", bus.Insq_ROB, 1'b1);
        tick();
        bus.rob_r = 32'd0;

        // 4: fill the queue, reject a 17th, then drain in order
        bus.rob_size = 32'd16;
        for (int i = 0; i < 16; i++) begin
            offer(32'h1000 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        offer(32'h2000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_full", bus.in_ready, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        bus.rob_size = 32'd15;
        bus.rob_r = 32'd10;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("t4_insq", bus.Insq_ROB, 1'b1);
            chk("t4_pc", bus.rob_pc_, 32'h1000 + 32'(4 * i));
            chk("t4_data1", bus.data1, 32'((11 + i) % 16));
            tick();
            bus.rob_r = (bus.rob_r + 32'd1) % 32'd16;
        end
        @(negedge clk);
        chk("t4_drained", bus.Insq_ROB, 1'b0);
        tick();
        bus.rob_size = 32'd0;
        bus.rob_r = 32'd0;

        // 5: clear with a concurrent push drops everything
        bus.rob_size = 32'd16;
        for (int i = 0; i < 5; i++) push1(32'h3000 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        offer(32'h3100, 1'b0, 1'b0, 1'b0);
        bus.clear = 1'b1;
        bus.rob_size = 32'd0;
        @(negedge clk);
        chk("t5_clear_insq", bus.Insq_ROB, 1'b0);
        tick();
        bus.clear = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_after", bus.Insq_ROB, 1'b0);
            tick();
        end

        // 6: blocked load stalls the younger ADD
        bus.slb_full = 1'b1;
        push1(32'h4000, 1'b1, 1'b0, 1'b0);
        push1(32'h4004, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_stall", bus.Insq_ROB, 1'b0);
        tick();
        bus.slb_full = 1'b0;
        @(negedge clk);
        chk("t6_load_slb", bus.to_slb, 1'b1);
        chk("t6_load_pc", bus.rob_pc_, 32'h4000);
        tick();
        @(negedge clk);
        chk("t6_add_rs", bus.to_rs, 1'b1);
        chk("t6_add_pc", bus.rob_pc_, 32'h4004);
        tick();

        // rdy low: no push, no fire
        bus.rdy = 1'b0;
        push1(32'h5000, 1'b0, 1'b0, 1'b0);
        bus.rdy = 1'b1;
        @(negedge clk);
        chk("rdy_nopush", bus.Insq_ROB, 1'b0);
        tick();

        // rdy low freezes a ready head
        bus.rob_size = 32'd16;
        push1(32'h5100, 1'b0, 1'b0, 1'b0);
        bus.rdy = 1'b0;
        bus.rob_size = 32'd0;
        @(negedge clk);
        chk("rdy_hold", bus.Insq_ROB, 1'b0);
        tick();
        bus.rdy = 1'b1;
        @(negedge clk);
        chk("rdy_resume_pc", bus.rob_pc_, 32'h5100);
        tick();

        // streaming: push and pop in the same cycle
        for (int i = 0; i < 6; i++) begin
            offer(32'h6000 + 32'(4 * i), i[0], 1'b0, 1'b0);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();

        // rst mid-operation discards the queue
        bus.rob_size = 32'd16;
        push1(32'h7000, 1'b0, 1'b0, 1'b0);
        push1(32'h7004, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.rob_size = 32'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_mid", bus.Insq_ROB, 1'b0);
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
